// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Execute-stage branch/call/return resolution with registered redirect
//            and optional circular return-address stack (BRANCH_RESOLVE_RAS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
   parameter int XLEN      = 19,
   parameter int AW        = 19,
   parameter int RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_i,
   input  logic                         is_b_type_ctl_i,
   input  logic [2:0]                   instr_func3_ctl_i,
   input  logic [XLEN-1:0]              opr_a_i,
   input  logic [XLEN-1:0]              opr_b_i,
   input  logic [AW-1:0]                pc_i,
   input  logic [AW-1:0]                imm_target_i,
   input  logic                         stall_i,
   input  logic                         flush_i,
   output logic                         valid_o,
   output logic                         branch_taken_o,
   output logic [AW-1:0]                target_o,
   output logic                         ras_overflow_o,
   output logic                         ras_underflow_o,
   output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] F_BEQ  = 3'd0;
   localparam logic [2:0] F_BNE  = 3'd1;
   localparam logic [2:0] F_BLT  = 3'd2;
   localparam logic [2:0] F_BGE  = 3'd3;
   localparam logic [2:0] F_BLTU = 3'd4;
   localparam logic [2:0] F_BGEU = 3'd5;
   localparam logic [2:0] F_CALL = 3'd6;
   localparam logic [2:0] F_RET  = 3'd7;

   logic          accept_w;
   logic          is_call_w;
   logic          is_ret_w;
   logic          cond_w;
   logic          ovf_w;
   logic          unf_w;
   logic [AW-1:0] ret_target_w;
   logic [AW-1:0] target_w;

   logic          valid_q,  valid_d;
   logic          taken_q,  taken_d;
   logic          ovf_q,    ovf_d;
   logic          unf_q,    unf_d;
   logic [AW-1:0] target_q, target_d;

   assign accept_w  = valid_i & is_b_type_ctl_i & ~stall_i & ~flush_i;
   assign is_call_w = (instr_func3_ctl_i == F_CALL);
   assign is_ret_w  = (instr_func3_ctl_i == F_RET);

   always_comb begin
      cond_w = 1'b0;
      case (instr_func3_ctl_i)
         F_BEQ:   cond_w = (opr_a_i == opr_b_i);
         F_BNE:   cond_w = (opr_a_i != opr_b_i);
         F_BLT:   cond_w = ($signed(opr_a_i) <  $signed(opr_b_i));
         F_BGE:   cond_w = ($signed(opr_a_i) >= $signed(opr_b_i));
         F_BLTU:  cond_w = (opr_a_i <  opr_b_i);
         F_BGEU:  cond_w = (opr_a_i >= opr_b_i);
         default: cond_w = 1'b1;
      endcase
   end

`ifdef BRANCH_RESOLVE_RAS_EN
   logic [AW-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0] sp_q,  sp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] top_idx_w;
   logic          ras_empty_w;
   logic          ras_full_w;
   logic          push_w;
   logic          pop_w;

   // sp_q points at the next free slot; the top entry sits just below it.
   assign top_idx_w    = sp_q - PW'(1);
   assign ras_empty_w  = (cnt_q == '0);
   assign ras_full_w   = (cnt_q == CW'(RAS_DEPTH));
   assign push_w       = accept_w & is_call_w;
   assign pop_w        = accept_w & is_ret_w;
   assign ovf_w        = push_w & ras_full_w;
   assign unf_w        = pop_w & ras_empty_w;
   assign ret_target_w = ras_empty_w ? opr_a_i[AW-1:0] : ras_q[top_idx_w];

   always_comb begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
      if (push_w) begin
         sp_d = sp_q + PW'(1);
         if (!ras_full_w) cnt_d = cnt_q + CW'(1);
      end else if (pop_w && !ras_empty_w) begin
         sp_d  = top_idx_w;
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q  <= '0;
         cnt_q <= '0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_w) ras_q[sp_q] <= pc_i + AW'(1);
   end

   assign ras_count_o = cnt_q;
`else
   logic unused_pc_w;

   assign unused_pc_w  = ^pc_i;
   assign ovf_w        = 1'b0;
   assign unf_w        = 1'b0;
   assign ret_target_w = opr_a_i[AW-1:0];
   assign ras_count_o  = '0;
`endif

   assign target_w = is_ret_w ? ret_target_w : imm_target_i;

   // Flush wins over stall; a stall holds the result but never re-issues a pulse.
   always_comb begin
      valid_d  = 1'b0;
      taken_d  = 1'b0;
      target_d = target_q;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (stall_i) begin
         valid_d = valid_q;
         taken_d = taken_q;
      end else if (accept_w) begin
         valid_d  = 1'b1;
         taken_d  = cond_w;
         target_d = target_w;
         ovf_d    = ovf_w;
         unf_d    = unf_w;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         taken_q  <= 1'b0;
         target_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         taken_q  <= taken_d;
         target_q <= target_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign valid_o         = valid_q;
   assign branch_taken_o  = taken_q;
   assign target_o        = target_q;
   assign ras_overflow_o  = ovf_q;
   assign ras_underflow_o = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit (either RAS build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

   localparam int XLEN      = 19;
   localparam int AW        = 19;
   localparam int RAS_DEPTH = 8;
`ifdef BRANCH_RESOLVE_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   localparam logic [2:0] F_BEQ  = 3'd0;
   localparam logic [2:0] F_BNE  = 3'd1;
   localparam logic [2:0] F_BLT  = 3'd2;
   localparam logic [2:0] F_BGE  = 3'd3;
   localparam logic [2:0] F_BLTU = 3'd4;
   localparam logic [2:0] F_BGEU = 3'd5;
   localparam logic [2:0] F_CALL = 3'd6;
   localparam logic [2:0] F_RET  = 3'd7;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       valid_i;
   logic                       is_b_type_ctl_i;
   logic [2:0]                 instr_func3_ctl_i;
   logic [XLEN-1:0]            opr_a_i;
   logic [XLEN-1:0]            opr_b_i;
   logic [AW-1:0]              pc_i;
   logic [AW-1:0]              imm_target_i;
   logic                       stall_i;
   logic                       flush_i;
   logic                       valid_o;
   logic                       branch_taken_o;
   logic [AW-1:0]              target_o;
   logic                       ras_overflow_o;
   logic                       ras_underflow_o;
   logic [$clog2(RAS_DEPTH):0] ras_count_o;

   int n_vec = 0;
   int n_err = 0;

   branch_resolve_unit #(
      .XLEN(XLEN), .AW(AW), .RAS_DEPTH(RAS_DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .valid_i           (valid_i),
      .is_b_type_ctl_i   (is_b_type_ctl_i),
      .instr_func3_ctl_i (instr_func3_ctl_i),
      .opr_a_i           (opr_a_i),
      .opr_b_i           (opr_b_i),
      .pc_i              (pc_i),
      .imm_target_i      (imm_target_i),
      .stall_i           (stall_i),
      .flush_i           (flush_i),
      .valid_o           (valid_o),
      .branch_taken_o    (branch_taken_o),
      .target_o          (target_o),
      .ras_overflow_o    (ras_overflow_o),
      .ras_underflow_o   (ras_underflow_o),
      .ras_count_o       (ras_count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic [2:0] f,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] bb,
                        input logic [AW-1:0] pc, input logic [AW-1:0] imm);
      valid_i           = v;
      is_b_type_ctl_i   = b;
      instr_func3_ctl_i = f;
      opr_a_i           = a;
      opr_b_i           = bb;
      pc_i              = pc;
      imm_target_i      = imm;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic t, input logic [AW-1:0] tgt);
      check({tag, ".valid"},  32'(valid_o),        32'(v));
      check({tag, ".taken"},  32'(branch_taken_o), 32'(t));
      check({tag, ".target"}, 32'(target_o),       32'(tgt));
   endtask

   initial begin
      reset   = 1'b1;
      stall_i = 1'b0;
      flush_i = 1'b0;
      drive(1'b0, 1'b0, F_BEQ, '0, '0, '0, '0);
      tick();
      tick();
      reset = 1'b0;
      check_out("reset", 1'b0, 1'b0, 19'h0);
      check("reset.count", 32'(ras_count_o),     32'd0);
      check("reset.ovf",   32'(ras_overflow_o),  32'd0);
      check("reset.unf",   32'(ras_underflow_o), 32'd0);

      // Signed vs unsigned compares with -1 against +1
      drive(1'b1, 1'b1, F_BLT, 19'h7FFFF, 19'h00001, 19'h040, 19'h200);
      tick();
      check_out("blt", 1'b1, 1'b1, 19'h200);
      drive(1'b1, 1'b1, F_BLTU, 19'h7FFFF, 19'h00001, 19'h041, 19'h201);
      tick();
      check_out("bltu", 1'b1, 1'b0, 19'h201);
      drive(1'b1, 1'b1, F_BGEU, 19'h7FFFF, 19'h00001, 19'h042, 19'h202);
      tick();
      check("bgeu.taken", 32'(branch_taken_o), 32'd1);
      drive(1'b1, 1'b1, F_BGE, 19'h7FFFF, 19'h00001, 19'h043, 19'h203);
      tick();
      check("bge.taken", 32'(branch_taken_o), 32'd0);

      drive(1'b1, 1'b1, F_BEQ, 19'h12345, 19'h12345, 19'h044, 19'h204);
      tick();
      check_out("beq", 1'b1, 1'b1, 19'h204);
      drive(1'b1, 1'b1, F_BNE, 19'h12345, 19'h12345, 19'h045, 19'h205);
      tick();
      check_out("bne", 1'b1, 1'b0, 19'h205);
      drive(1'b1, 1'b1, F_BEQ, 19'h12345, 19'h52345, 19'h046, 19'h206);
      tick();
      check("beq_msb.taken", 32'(branch_taken_o), 32'd0);

      // Non-branch: result dropped, target held
      drive(1'b1, 1'b0, F_CALL, 19'h1, 19'h1, 19'h047, 19'h207);
      tick();
      check_out("nonbr", 1'b0, 1'b0, 19'h206);
      check("nonbr.count", 32'(ras_count_o), 32'd0);

      // Back-to-back CALL then RET
      drive(1'b1, 1'b1, F_CALL, 19'h0, 19'h0, 19'h100, 19'h300);
      tick();
      check_out("call", 1'b1, 1'b1, 19'h300);
      check("call.count", 32'(ras_count_o), RAS ? 32'd1 : 32'd0);
      drive(1'b1, 1'b1, F_RET, 19'h00055, 19'h0, 19'h101, 19'h301);
      tick();
      check_out("ret", 1'b1, 1'b1, RAS ? 19'h101 : 19'h00055);
      check("ret.count", 32'(ras_count_o), 32'd0);

      // Nine CALLs overflow an 8-deep stack
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, F_CALL, 19'h0, 19'h0, AW'(32'h10 + i), AW'(32'h400 + i));
         tick();
         check($sformatf("ovf_call%0d.count", i), 32'(ras_count_o),
               RAS ? ((i < 8) ? 32'(i + 1) : 32'd8) : 32'd0);
         check($sformatf("ovf_call%0d.ovf", i), 32'(ras_overflow_o),
               (RAS && i == 8) ? 32'd1 : 32'd0);
      end
      for (int j = 0; j < 8; j++) begin
         drive(1'b1, 1'b1, F_RET, 19'h07ABC, 19'h0, 19'h0, 19'h0);
         tick();
         check($sformatf("pop%0d.target", j), 32'(target_o),
               RAS ? 32'(32'h19 - j) : 32'h7ABC);
         check($sformatf("pop%0d.count", j), 32'(ras_count_o),
               RAS ? 32'(7 - j) : 32'd0);
      end
      drive(1'b1, 1'b1, F_RET, 19'h03333, 19'h0, 19'h0, 19'h0);
      tick();
      check_out("unf", 1'b1, 1'b1, 19'h03333);
      check("unf.pulse", 32'(ras_underflow_o), RAS ? 32'd1 : 32'd0);
      check("unf.count", 32'(ras_count_o), 32'd0);
      drive(1'b0, 1'b0, F_BEQ, '0, '0, '0, '0);
      tick();
      check("unf_end.pulse", 32'(ras_underflow_o), 32'd0);
      check("idle.valid", 32'(valid_o), 32'd0);

      // Stall holds outputs and RAS for three cycles
      drive(1'b1, 1'b1, F_CALL, 19'h0, 19'h0, 19'h020, 19'h500);
      tick();
      check_out("pre_stall", 1'b1, 1'b1, 19'h500);
      drive(1'b1, 1'b1, F_BNE, 19'h00007, 19'h00007, 19'h021, 19'h600);
      stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_out($sformatf("stall%0d", k), 1'b1, 1'b1, 19'h500);
         check($sformatf("stall%0d.count", k), 32'(ras_count_o), RAS ? 32'd1 : 32'd0);
      end
      stall_i = 1'b0;
      tick();
      check_out("unstall", 1'b1, 1'b0, 19'h600);

      // Flushed CALL makes no RAS update
      drive(1'b1, 1'b1, F_CALL, 19'h0, 19'h0, 19'h030, 19'h700);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check_out("flush", 1'b0, 1'b0, 19'h600);
      check("flush.count", 32'(ras_count_o), RAS ? 32'd1 : 32'd0);

      // Mid-stream reset with count 5 and a valid result
      for (int m = 0; m < 4; m++) begin
         drive(1'b1, 1'b1, F_CALL, 19'h0, 19'h0, AW'(32'h40 + m), 19'h710);
         tick();
      end
      check("pre_rst.count", 32'(ras_count_o), RAS ? 32'd5 : 32'd0);
      check("pre_rst.valid", 32'(valid_o), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_out("mid_rst", 1'b0, 1'b0, 19'h0);
      check("mid_rst.count", 32'(ras_count_o), 32'd0);
      drive(1'b1, 1'b1, F_RET, 19'h00077, 19'h0, 19'h0, 19'h0);
      tick();
      check_out("post_rst_ret", 1'b1, 1'b1, 19'h00077);
      check("post_rst_ret.unf", 32'(ras_underflow_o), RAS ? 32'd1 : 32'd0);
      drive(1'b0, 1'b0, F_BEQ, '0, '0, '0, '0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
